// File: rtl/sync_fifo_flagged_if.sv
// sync_fifo_flagged_if
//   Bundles the producer/consumer side of sync_fifo_flagged into one interface.
//   master : the user of the FIFO (drives w_en/data_in/r_en/clr_err)
//   slave  : the FIFO itself (drives data_out, occupancy and status flags)
// Signals
//   w_en, data_in        write request and data
//   r_en                 read request (FWFT: pop/acknowledge)
//   data_out             read data
//   full, empty          occupancy extremes
//   almost_full/_empty   threshold flags
//   count                occupancy, 0..DEPTH
//   clr_err              synchronous clear of the sticky error flags
//   overflow, underflow  sticky error flags
interface sync_fifo_flagged_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    logic                     w_en;
    logic [WIDTH-1:0]         data_in;
    logic                     r_en;
    logic [WIDTH-1:0]         data_out;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     clr_err;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output w_en, data_in, r_en, clr_err,
        input  data_out, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  w_en, data_in, r_en, clr_err,
        output data_out, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flagged.sv
// sync_fifo_flagged
//   Single-clock FIFO using pointers with one extra MSB, so all DEPTH slots are
//   usable. Provides a registered occupancy count, almost-full/almost-empty
//   thresholds and sticky overflow/underflow flags. FWFT selects registered
//   (1-cycle latency) or first-word-fall-through read data.
// Ports
//   clk   clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   sync_fifo_flagged_if.slave (see interface for signal list)
module sync_fifo_flagged #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4,
    parameter bit FWFT     = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_flagged_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             overflow_q;
    logic             underflow_q;

    logic full_w;
    logic empty_w;
    logic rd_ok;
    logic wr_ok;

    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_ok = bus.r_en & ~empty_w;
    assign wr_ok = bus.w_en & (~full_w | rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;

            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            // A fresh error event takes priority over clr_err.
            if (bus.w_en && !wr_ok)  overflow_q <= 1'b1;
            else if (bus.clr_err)    overflow_q <= 1'b0;

            if (bus.r_en && empty_w) underflow_q <= 1'b1;
            else if (bus.clr_err)    underflow_q <= 1'b0;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is visible as soon as it is stored; forced to 0 when empty.
            assign bus.data_out = empty_w ? '0 : mem[rd_ptr[AW-1:0]];
        end else begin : g_reg
            logic [WIDTH-1:0] data_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q <= '0;
                end else if (rd_ok) begin
                    data_q <= mem[rd_ptr[AW-1:0]];
                end
            end

            assign bus.data_out = data_q;
        end
    endgenerate

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.count        = count_q;
    assign bus.almost_full  = (count_q >= PW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= PW'(AE_LEVEL));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// tb_sync_fifo_flagged
//   Drives identical traffic into a registered-read instance (dut0) and an
//   FWFT instance (dut1). A queue model predicts the post-edge state of both;
//   predictions go into exp_q and a negedge monitor pops and compares them.
module tb_sync_fifo_flagged;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic w_en = 1'b0, r_en = 1'b0, clr_err = 1'b0;
    logic [WIDTH-1:0] data_in = '0;

    always #5 clk = ~clk;

    sync_fifo_flagged_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
    sync_fifo_flagged_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();

    assign bus0.w_en = w_en;  assign bus0.data_in = data_in;
    assign bus0.r_en = r_en;  assign bus0.clr_err = clr_err;
    assign bus1.w_en = w_en;  assign bus1.data_in = data_in;
    assign bus1.r_en = r_en;  assign bus1.clr_err = clr_err;

    sync_fifo_flagged #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sync_fifo_flagged #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        int unsigned chk_cyc;
        int          id;
        logic [31:0] cnt;
        logic        full, empty, af, ae, ovf, unf;
        logic [7:0]  do0, do1;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;
    int op_id = 0;

    // reference model
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0, m_unf = 1'b0;
    logic [7:0] m_do0 = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model_state();
        exp_t e;
        e.chk_cyc = 0;
        e.id      = op_id;
        e.cnt     = mq.size();
        e.full    = (mq.size() == DEPTH);
        e.empty   = (mq.size() == 0);
        e.af      = (mq.size() >= AF);
        e.ae      = (mq.size() <= AE);
        e.ovf     = m_ovf;
        e.unf     = m_unf;
        e.do0     = m_do0;
        e.do1     = (mq.size() == 0) ? 8'h00 : mq[0];
        return e;
    endfunction

    task automatic cmp_all(input string tag, input exp_t e);
        chk({tag, " d0.count"},        32'(bus0.count),   e.cnt);
        chk({tag, " d0.full"},         32'(bus0.full),    32'(e.full));
        chk({tag, " d0.empty"},        32'(bus0.empty),   32'(e.empty));
        chk({tag, " d0.almost_full"},  32'(bus0.almost_full),  32'(e.af));
        chk({tag, " d0.almost_empty"}, 32'(bus0.almost_empty), 32'(e.ae));
        chk({tag, " d0.overflow"},     32'(bus0.overflow),  32'(e.ovf));
        chk({tag, " d0.underflow"},    32'(bus0.underflow), 32'(e.unf));
        chk({tag, " d0.data_out"},     32'(bus0.data_out),  32'(e.do0));
        chk({tag, " d1.count"},        32'(bus1.count),   e.cnt);
        chk({tag, " d1.empty"},        32'(bus1.empty),   32'(e.empty));
        chk({tag, " d1.overflow"},     32'(bus1.overflow),  32'(e.ovf));
        chk({tag, " d1.underflow"},    32'(bus1.underflow), 32'(e.unf));
        chk({tag, " d1.data_out"},     32'(bus1.data_out),  32'(e.do1));
    endtask

    // monitor: compares every prediction due in the cycle just completed
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].chk_cyc == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp_all($sformatf("op%0d", e.id), e);
        end
    end

    // one clock of stimulus; called just after a falling edge
    task automatic op(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic was_empty, rd_ok, wr_ok;
        exp_t e;
        w_en = w; data_in = d; r_en = r; clr_err = c;
        was_empty = (mq.size() == 0);
        rd_ok = r && !was_empty;
        wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
        if (rd_ok) m_do0 = mq.pop_front();
        if (wr_ok) mq.push_back(d);
        if (w && !wr_ok)       m_ovf = 1'b1;
        else if (c)            m_ovf = 1'b0;
        if (r && was_empty)    m_unf = 1'b1;
        else if (c)            m_unf = 1'b0;
        op_id++;
        e = model_state();
        e.chk_cyc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_do0 = 8'h00;
    endtask

    initial begin
        model_reset();
        #1;
        cmp_all("reset", model_state());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) op(1'b1, 8'(i), 1'b0, 1'b0);
        // 2: rejected write while full, then clear
        op(1'b1, 8'hAA, 1'b0, 1'b0);
        op(1'b0, 8'h00, 1'b0, 1'b1);
        // 3: drain, one extra read on empty, clear
        for (int i = 0; i < 16; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
        op(1'b0, 8'h00, 1'b1, 1'b0);
        op(1'b0, 8'h00, 1'b0, 1'b1);
        // 4: simultaneous read/write on full, 0x55 comes out 16th
        for (int i = 0; i < 16; i++) op(1'b1, 8'(i), 1'b0, 1'b0);
        op(1'b1, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
        // write and read together on empty: write taken, underflow set
        op(1'b1, 8'h77, 1'b1, 1'b0);
        op(1'b0, 8'h00, 1'b1, 1'b1);
        // 5: single word into empty FIFO (FWFT fall-through), then pop
        op(1'b1, 8'h3C, 1'b0, 1'b0);
        op(1'b0, 8'h00, 1'b1, 1'b0);
        // 6: build count=7 then reset between edges
        for (int i = 0; i < 8; i++) op(1'b1, 8'(8'hA0 + i), (i == 3), 1'b0);
        op(1'b1, 8'hEE, 1'b0, 1'b0);
        op(1'b0, 8'h00, 1'b1, 1'b0);
        #2;
        w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        cmp_all("rst_mid", model_state());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            op($urandom_range(0, 9) < 6, 8'($urandom_range(0, 255)),
               $urandom_range(0, 9) < 5, $urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
